// File: rtl/inst_queue_pkg.sv
// Shared fetch/decode types: exception codes, the fetch entry
// bundle and the default instruction queue depth.
package inst_queue_pkg;

  typedef enum logic [2:0] {
    EXC_NONE = 3'd0,
    EXC_INT  = 3'd1,
    EXC_ADEF = 3'd2,
    EXC_TLBR = 3'd3,
    EXC_PIF  = 3'd4,
    EXC_PPI  = 3'd5
  } exception_t;

  localparam int IQ_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        have_exception;
    exception_t  exception_type;
    logic        pred_taken;
    logic [31:0] pred_target;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Two-in / two-out instruction queue decoupling fetch from the
// dual decoder slots; flushed by backend redirects.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic [1:0]            in_valid,
  input  logic [1:0][31:0]      in_pc,
  input  logic [1:0][31:0]      in_inst,
  input  logic [1:0]            in_have_exception,
  input  exception_t [1:0]      in_exception_type,
  input  logic [1:0]            in_pred_taken,
  input  logic [1:0][31:0]      in_pred_target,
  output logic                  in_ready,
  output logic [1:0]            out_valid,
  output logic [1:0][31:0]      out_pc,
  output logic [1:0][31:0]      out_inst,
  output logic [1:0]            out_have_exception,
  output exception_t [1:0]      out_exception_type,
  output logic [1:0]            out_pred_taken,
  output logic [1:0][31:0]      out_pred_target,
  input  logic [1:0]            out_accept
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] READY_MAX = (PTR_W+1)'(DEPTH - 2);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_TWO = (PTR_W+1)'(2);

  fetch_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [PTR_W:0]       r_count;

  logic [PTR_W-1:0]     w_head1;
  logic [PTR_W-1:0]     w_tail1;
  logic                 w_push;
  logic                 w_push2;
  logic                 w_pop0;
  logic                 w_pop1;
  logic [PTR_W:0]       w_push_n;
  logic [PTR_W:0]       w_pop_n;
  fetch_entry_t [1:0]   w_in;
  fetch_entry_t [1:0]   w_out;

  assign w_head1 = r_head + PTR_W'(1);
  assign w_tail1 = r_tail + PTR_W'(1);

  // Credit only the registered count, so pops never reach in_ready.
  assign in_ready  = (r_count <= READY_MAX);
  assign out_valid = {r_count >= CNT_TWO, r_count >= CNT_ONE};

  assign w_push  = in_ready & in_valid[0] & ~flush;
  assign w_push2 = w_push & in_valid[1] & ~in_pred_taken[0];
  assign w_pop0  = out_accept[0] & out_valid[0];
  assign w_pop1  = out_accept[1] & out_valid[1];

  assign w_push_n = {{PTR_W{1'b0}}, w_push}
                  + {{PTR_W{1'b0}}, w_push2};
  assign w_pop_n  = {{PTR_W{1'b0}}, w_pop0}
                  + {{PTR_W{1'b0}}, w_pop1};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_in[i].pc             = in_pc[i];
      w_in[i].inst           = in_inst[i];
      w_in[i].have_exception = in_have_exception[i];
      w_in[i].exception_type = in_exception_type[i];
      w_in[i].pred_taken     = in_pred_taken[i];
      w_in[i].pred_target    = in_pred_target[i];
    end
  end

  assign w_out[0] = r_mem[r_head];
  assign w_out[1] = r_mem[w_head1];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      out_pc[i]             = w_out[i].pc;
      out_inst[i]           = w_out[i].inst;
      out_have_exception[i] = w_out[i].have_exception;
      out_exception_type[i] = w_out[i].exception_type;
      out_pred_taken[i]     = w_out[i].pred_taken;
      out_pred_target[i]    = w_out[i].pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)  r_mem[r_tail]  <= w_in[0];
    if (w_push2) r_mem[w_tail1] <= w_in[1];
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + w_pop_n[PTR_W-1:0];
      r_tail  <= r_tail + w_push_n[PTR_W-1:0];
      r_count <= r_count + w_push_n - w_pop_n;
    end
  end

  a_accept_prefix: assert property (
    @(posedge clk) disable iff (!resetn)
    out_accept != 2'b10
  );

endmodule
